vga_sync_entity_latch: RTL
==========================

Name: vga_sync_entity_latch

Overview:
Upstream stage of the frame buffer controller. Generates the 640x480@60 VGA timing (the counter_H/counter_V pair the frame buffer consumes) and the hsync/vsync/display_on strobes. Also holds a shadow copy of the nine entity words, which is updated only at the start of vertical blanking through a req/ack handshake with the game control logic. The renderer therefore never sees an entity change in mid-frame.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
ENTITY_W, 14, entity word width ([13:10] ID, [9:8] orientation, [7:0] tile)

Ports:
clk  input  1  pixel clock (25 MHz nominal)
reset  input  1  asynchronous, active-high reset
entity_in_1..entity_in_9  input  ENTITY_W each  staged entity words from game logic (8 and 9 are the flip channels)
update_req  input  1  game logic requests a shadow update; entity_in_* held stable while high
update_ack  output  1  one-cycle pulse: shadow captured
entity_1..entity_7, entity_8_Flip, entity_9_Flip  output  ENTITY_W each  shadow entity words to the frame buffer
counter_H  output  10  horizontal pixel counter
counter_V  output  10  vertical line counter
hsync  output  1  active-low horizontal sync
vsync  output  1  active-low vertical sync
display_on  output  1  high inside the visible 640x480 area
frame_tick  output  1  one-cycle pulse on the first clock of each frame (H=0, V=0)

Behaviour:
- Derived values: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset (async, active-high) sets:
  - counter_H = 0, counter_V = 0
  - all shadow entities = 14'h3C00 (ID 4'hf, unused)
  - update_ack = 0, frame_tick = 0
  - hsync = 1, vsync = 1, display_on = 0 (registered outputs; see Optional Feature)
- Counters:
  - counter_H increments every clk and wraps H_TOTAL-1 -> 0.
  - counter_V increments only on the clk where counter_H wraps; it wraps V_TOTAL-1 -> 0 on that same clk.
  - Counter values are never outside 0..H_TOTAL-1 or 0..V_TOTAL-1.
- Sync decode, from the current counter values:
  - hsync = 0 iff H_ACTIVE+H_FRONT <= counter_H < H_ACTIVE+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync = 0 iff V_ACTIVE+V_FRONT <= counter_V < V_ACTIVE+V_FRONT+V_SYNC, i.e. 490..491.
  - display_on = (counter_H < H_ACTIVE) && (counter_V < V_ACTIVE).
- frame_tick:
  - Registered; high for exactly one clk per frame, coincident with counter_H=0, counter_V=0.
  - Not asserted on the first cycle after reset release; the first pulse comes after one full frame.
- Latch point: the clk edge where counter_H = H_TOTAL-1 and counter_V = V_ACTIVE-1 (end of the last visible line).
- Handshake:
  - If update_req = 1 at the latch point, all nine shadows take entity_in_* on that edge.
  - update_ack pulses high for the following single clk.
  - If update_req = 0 at the latch point, the shadows hold their value and no ack is issued.
  - Game logic must drop update_req within one frame after the ack. If update_req is still high at the next latch point, the block captures again and acks again (level-sensitive, no edge detect).
  - update_req toggling outside the latch point has no effect.
- Shadows change only at the latch point. Every pixel of a visible frame therefore sees identical entity words.
- Reset mid-frame: counters return to 0 immediately, shadows are cleared to unused, and any pending request is dropped (the request must be re-asserted).

Optional Feature:
Macro VGA_SYNC_ALIGN_EN.
- Defined: hsync, vsync and display_on pass through one extra register stage. They lag counter_H/counter_V by 1 clk, matching the 1-clk registered SpriteROM latency in the frame buffer, so the sync strobes line up with colour.
- Not defined: the three strobes are registered together with the counters and reflect the current counter value with 0 lag.
- frame_tick timing is identical in both builds.

Test Plan:
- Release reset, run 800*525 clks -> counter_H wraps 799->0 every 800 clks; counter_V wraps 524->0; frame_tick seen once, at H=0/V=0 after exactly 420000 clks.
- Monitor strobes for one frame -> hsync low exactly for H=656..751 (96 clks per line); vsync low for lines 490..491 only; display_on high for exactly 307200 clks per frame.
- Set entity_in_1=14'h0412, hold update_req=1 from V=100 -> entity_1 stays 14'h3C00 until the edge at H=799/V=479, then reads 14'h0412; update_ack is high for exactly 1 clk.
- Pulse update_req for 1 clk at V=200 only -> no capture and no ack; shadows are unchanged at the next frame.
- Assert reset at H=300/V=250 after an update has been applied -> counters are 0 and all shadows are 14'h3C00 immediately (async); after release, timing restarts cleanly from 0/0.
- Build with VGA_SYNC_ALIGN_EN -> hsync first falls on the clk after counter_H=656 (1-clk lag versus the non-macro build); frame_tick timing is unchanged.

Source files
------------

// File: rtl/vga_sync_entity_latch.sv
// -----------------------------------------------------------------------------
// vga_sync_entity_latch
//
// Purpose:
//   Generates 640x480@60 VGA timing by default (pixel/line counters plus the
//   hsync/vsync/display_on strobes and a per-frame tick). It also keeps a shadow
//   copy of the nine entity words. The shadow is refreshed only at the end of
//   the last visible line, through a level-sensitive req/ack handshake, so the
//   renderer never sees an entity change part-way through a frame.
//
// Ports:
//   clk               pixel clock
//   reset             asynchronous, active-high reset
//   entity_in_1..9    staged entity words from game logic (8/9 = flip channels)
//   update_req        shadow update request (entity_in_* stable while high)
//   update_ack        one-cycle pulse after the shadow has been captured
//   entity_1..7,
//   entity_8_Flip,
//   entity_9_Flip     shadow entity words to the frame buffer
//   counter_H/V       horizontal pixel / vertical line counters
//   hsync, vsync      active-low sync strobes
//   display_on        high inside the visible area
//   frame_tick        one-cycle pulse at H=0/V=0 (not on the first cycle after reset)
//
// Build option:
//   VGA_SYNC_ALIGN_EN  when defined, hsync/vsync/display_on lag the counters by
//                      one clock to line up with the frame buffer's registered
//                      sprite ROM. frame_tick timing is the same in both builds.
// -----------------------------------------------------------------------------
module vga_sync_entity_latch #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int ENTITY_W = 14
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ENTITY_W-1:0] entity_in_1,
   input  logic [ENTITY_W-1:0] entity_in_2,
   input  logic [ENTITY_W-1:0] entity_in_3,
   input  logic [ENTITY_W-1:0] entity_in_4,
   input  logic [ENTITY_W-1:0] entity_in_5,
   input  logic [ENTITY_W-1:0] entity_in_6,
   input  logic [ENTITY_W-1:0] entity_in_7,
   input  logic [ENTITY_W-1:0] entity_in_8,
   input  logic [ENTITY_W-1:0] entity_in_9,
   input  logic                update_req,
   output logic                update_ack,
   output logic [ENTITY_W-1:0] entity_1,
   output logic [ENTITY_W-1:0] entity_2,
   output logic [ENTITY_W-1:0] entity_3,
   output logic [ENTITY_W-1:0] entity_4,
   output logic [ENTITY_W-1:0] entity_5,
   output logic [ENTITY_W-1:0] entity_6,
   output logic [ENTITY_W-1:0] entity_7,
   output logic [ENTITY_W-1:0] entity_8_Flip,
   output logic [ENTITY_W-1:0] entity_9_Flip,
   output logic [9:0]          counter_H,
   output logic [9:0]          counter_V,
   output logic                hsync,
   output logic                vsync,
   output logic                display_on,
   output logic                frame_tick
);

   localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [9:0] V_LATCH  = 10'(V_ACTIVE - 1);

   // ID 4'hF marks an unused entity slot.
   localparam logic [ENTITY_W-1:0] ENTITY_UNUSED = {4'hF, {(ENTITY_W-4){1'b0}}};

   // Strobe decode of a counter pair: {hsync_n, vsync_n, display_on}.
   function automatic logic [2:0] decode_strobes(input logic [9:0] h, input logic [9:0] v);
      logic hs_n, vs_n, de;
      hs_n = !((h >= H_SYNC_S) && (h < H_SYNC_E));
      vs_n = !((v >= V_SYNC_S) && (v < V_SYNC_E));
      de   = (h < H_ACT) && (v < V_ACT);
      return {hs_n, vs_n, de};
   endfunction

   logic [9:0]          h_q, h_d, v_q, v_d;
   logic                h_wrap, latch_pt, frame_d;
   logic [2:0]          strb_q, strb_d;
   logic                ack_q, tick_q;
   logic [ENTITY_W-1:0] ent_in   [9];
   logic [ENTITY_W-1:0] shadow_q [9];

   assign ent_in[0] = entity_in_1;
   assign ent_in[1] = entity_in_2;
   assign ent_in[2] = entity_in_3;
   assign ent_in[3] = entity_in_4;
   assign ent_in[4] = entity_in_5;
   assign ent_in[5] = entity_in_6;
   assign ent_in[6] = entity_in_7;
   assign ent_in[7] = entity_in_8;
   assign ent_in[8] = entity_in_9;

   always_comb begin
      h_wrap   = (h_q == H_LAST);
      h_d      = h_wrap ? 10'd0 : h_q + 10'd1;
      v_d      = v_q;
      if (h_wrap) begin
         v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end
      // End of the last visible line: the only edge the shadow may change on.
      latch_pt = h_wrap && (v_q == V_LATCH);
      // Tick is registered, so it is raised on the edge that enters H=0/V=0.
      frame_d  = h_wrap && (v_q == V_LAST);
   end

`ifdef VGA_SYNC_ALIGN_EN
   // Decode the current (registered) counters: strobes trail them by one clock.
   assign strb_d = decode_strobes(h_q, v_q);
`else
   // Decode the next counter values so the strobes match the counters exactly.
   assign strb_d = decode_strobes(h_d, v_d);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_q    <= 10'd0;
         v_q    <= 10'd0;
         strb_q <= 3'b110;
         ack_q  <= 1'b0;
         tick_q <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            shadow_q[i] <= ENTITY_UNUSED;
         end
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         strb_q <= strb_d;
         tick_q <= frame_d;
         if (latch_pt && update_req) begin
            for (int i = 0; i < 9; i++) begin
               shadow_q[i] <= ent_in[i];
            end
            ack_q <= 1'b1;
         end else begin
            ack_q <= 1'b0;
         end
      end
   end

   assign counter_H     = h_q;
   assign counter_V     = v_q;
   assign hsync         = strb_q[2];
   assign vsync         = strb_q[1];
   assign display_on    = strb_q[0];
   assign frame_tick    = tick_q;
   assign update_ack    = ack_q;
   assign entity_1      = shadow_q[0];
   assign entity_2      = shadow_q[1];
   assign entity_3      = shadow_q[2];
   assign entity_4      = shadow_q[3];
   assign entity_5      = shadow_q[4];
   assign entity_6      = shadow_q[5];
   assign entity_7      = shadow_q[6];
   assign entity_8_Flip = shadow_q[7];
   assign entity_9_Flip = shadow_q[8];

endmodule
